// File: rtl/minmax_pkg.sv
// minmax_pkg: shared types, reset constants and counter helper
// for the minmax_tracker4 streaming extreme tracker.
package minmax_pkg;

   typedef enum logic {
      EMPTY    = 1'b0,
      TRACKING = 1'b1
   } state_e;

   localparam logic [3:0] MAX_RST = 4'h0;
   localparam logic [3:0] MIN_RST = 4'hF;

   // Counters are at most 16 bits wide. Callers zero-extend into this
   // width and truncate the result. Because v < lim <= 16'hFFFF whenever
   // the add happens, the +1 cannot carry out.
   function automatic logic [15:0] sat_inc(
      input logic [15:0] v,
      input logic [15:0] lim
   );
      return (v >= lim) ? lim : v + 16'd1;
   endfunction

endpackage

// File: rtl/minmax_tracker4_if.sv
// minmax_tracker4_if: sample stream in, tracked extremes and counts out.
// The master drives samples; the slave is the tracker.
interface minmax_tracker4_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic [3:0]       in_data;
   logic             seeded;
   logic [3:0]       max_out;
   logic [3:0]       min_out;
   logic [CNT_W-1:0] max_cnt;
   logic [CNT_W-1:0] min_cnt;
   logic [CNT_W-1:0] sample_cnt;
   logic             new_max;
   logic             new_min;

   modport master (
      output in_valid, in_data,
      input  seeded, max_out, min_out,
      input  max_cnt, min_cnt, sample_cnt,
      input  new_max, new_min
   );

   modport slave (
      input  in_valid, in_data,
      output seeded, max_out, min_out,
      output max_cnt, min_cnt, sample_cnt,
      output new_max, new_min
   );
endinterface

// File: rtl/cmp4_flags.sv
// cmp4_flags: combinational 4-bit unsigned compare, one-hot gt/eq/lt.
module cmp4_flags (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);
   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);
endmodule

// File: rtl/minmax_tracker4.sv
// minmax_tracker4: running max/min of a 4-bit sample stream with
// saturating hit counts and a saturating sample count.
module minmax_tracker4
   import minmax_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   input logic               clr,
   minmax_tracker4_if.slave  bus
);

   localparam logic [15:0] CNT_LIM =
      16'((32'd1 << CNT_W) - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e state_q, state_d;

   logic [3:0]       max_q, max_d;
   logic [3:0]       min_q, min_d;
   logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
   logic [CNT_W-1:0] min_cnt_q, min_cnt_d;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic             new_max_q, new_max_d;
   logic             new_min_q, new_min_d;

   logic max_gt, max_eq, max_lt;
   logic min_gt, min_eq, min_lt;

   cmp4_flags u_cmp_max (
      .a  (bus.in_data),
      .b  (max_q),
      .gt (max_gt),
      .eq (max_eq),
      .lt (max_lt)
   );

   cmp4_flags u_cmp_min (
      .a  (bus.in_data),
      .b  (min_q),
      .gt (min_gt),
      .eq (min_eq),
      .lt (min_lt)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY:    if (bus.in_valid) state_d = TRACKING;
         TRACKING: state_d = TRACKING;
         default:  state_d = EMPTY;
      endcase
   end

   always_comb begin
      max_d     = max_q;
      min_d     = min_q;
      max_cnt_d = max_cnt_q;
      min_cnt_d = min_cnt_q;
      smp_cnt_d = smp_cnt_q;
      new_max_d = 1'b0;
      new_min_d = 1'b0;

      if (bus.in_valid) begin
         smp_cnt_d = CNT_W'(sat_inc(16'(smp_cnt_q), CNT_LIM));

         if (state_q == EMPTY) begin
            max_d     = bus.in_data;
            min_d     = bus.in_data;
            max_cnt_d = CNT_ONE;
            min_cnt_d = CNT_ONE;
            new_max_d = 1'b1;
            new_min_d = 1'b1;
         end else begin
            unique case (1'b1)
               max_gt: begin
                  max_d     = bus.in_data;
                  max_cnt_d = CNT_ONE;
                  new_max_d = 1'b1;
               end
               max_eq: max_cnt_d =
                  CNT_W'(sat_inc(16'(max_cnt_q), CNT_LIM));
               max_lt: ;
               default: ;
            endcase

            unique case (1'b1)
               min_lt: begin
                  min_d     = bus.in_data;
                  min_cnt_d = CNT_ONE;
                  new_min_d = 1'b1;
               end
               min_eq: min_cnt_d =
                  CNT_W'(sat_inc(16'(min_cnt_q), CNT_LIM));
               min_gt: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         max_q     <= MAX_RST;
         min_q     <= MIN_RST;
         max_cnt_q <= '0;
         min_cnt_q <= '0;
         smp_cnt_q <= '0;
         new_max_q <= 1'b0;
         new_min_q <= 1'b0;
      end else begin
         max_q     <= max_d;
         min_q     <= min_d;
         max_cnt_q <= max_cnt_d;
         min_cnt_q <= min_cnt_d;
         smp_cnt_q <= smp_cnt_d;
         new_max_q <= new_max_d;
         new_min_q <= new_min_d;
      end
   end

   assign bus.seeded     = (state_q == TRACKING);
   assign bus.max_out    = max_q;
   assign bus.min_out    = min_q;
   assign bus.max_cnt    = max_cnt_q;
   assign bus.min_cnt    = min_cnt_q;
   assign bus.sample_cnt = smp_cnt_q;
   assign bus.new_max    = new_max_q;
   assign bus.new_min    = new_min_q;

endmodule
